// File: rtl/cnn_layer_accel_weight_loader_if.sv
// Weight beat stream from the layer's weight fetch path into the weight loader.
interface cnn_layer_accel_weight_loader_if #(
  parameter int C_WEIGHT_WIDTH = 16
);
  logic                      wht_in_valid;
  logic                      wht_in_ready;
  logic [C_WEIGHT_WIDTH-1:0] wht_in_data;
  logic                      wht_in_last;

  modport master (
    output wht_in_valid,
    output wht_in_data,
    output wht_in_last,
    input  wht_in_ready
  );

  modport slave (
    input  wht_in_valid,
    input  wht_in_data,
    input  wht_in_last,
    output wht_in_ready
  );
endinterface

// File: rtl/cnn_layer_accel_weight_loader.sv
// Weight loader: streams 3x3 kernel weights into the CE weight table's
// configuration port, bracketing the load with config_mode and pulsing
// load_done when the table is ready for use.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | job_accept pulse, table enters configuration mode
// LOAD  | accepting weight beats, one table write per beat
// FLUSH | last write drains, config_mode held
// DONE  | load_done pulse, config_mode released
module cnn_layer_accel_weight_loader #(
  parameter int C_KERNEL_WORDS      = 9,
  parameter int C_NUM_KERNELS_WIDTH = 6,
  parameter int C_WEIGHT_WIDTH      = 16,
  parameter int C_FLUSH_CYCLES      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [C_NUM_KERNELS_WIDTH-1:0] i_num_kernels,
  cnn_layer_accel_weight_loader_if.slave i_wht,
  output logic                           o_config_mode,
  output logic                           o_job_accept,
  output logic                           o_wht_config_wren,
  output logic [C_WEIGHT_WIDTH-1:0]      o_wht_config_data,
  output logic                           o_load_done,
  output logic                           o_load_err,
  output logic [C_NUM_KERNELS_WIDTH-1:0] o_kernel_cnt
);

  localparam int LP_WORD_W  = (C_KERNEL_WORDS > 1) ? $clog2(C_KERNEL_WORDS) : 1;
  localparam int LP_FLUSH_W = (C_FLUSH_CYCLES > 1) ? $clog2(C_FLUSH_CYCLES) : 1;

  localparam logic [LP_WORD_W-1:0]  LP_WORD_LAST  = LP_WORD_W'(C_KERNEL_WORDS - 1);
  localparam logic [LP_FLUSH_W-1:0] LP_FLUSH_LOAD = LP_FLUSH_W'(C_FLUSH_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                     r_state;
  logic [LP_WORD_W-1:0]           r_word_cnt;
  logic [C_NUM_KERNELS_WIDTH-1:0] r_kernel_cnt;
  logic [C_NUM_KERNELS_WIDTH-1:0] r_num_kernels;
  logic [LP_FLUSH_W-1:0]          r_flush_cnt;
  logic                           r_load_err;
  logic                           r_wren;
  logic [C_WEIGHT_WIDTH-1:0]      r_data;

  logic w_ready;
  logic w_accept;
  logic w_word_wrap;
  logic w_final;

  assign w_ready     = (r_state == S_LOAD);
  assign w_accept    = i_wht.wht_in_valid && w_ready;
  assign w_word_wrap = (r_word_cnt == LP_WORD_LAST);
  // The final beat is recognised by position, so wht_in_last is only a
  // consistency check and can never make the table overrun.
  assign w_final     = w_word_wrap && (r_kernel_cnt == r_num_kernels);

  // Sequencing FSM with word/kernel counters and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_word_cnt    <= '0;
      r_kernel_cnt  <= '0;
      r_num_kernels <= '0;
      r_flush_cnt   <= '0;
      r_load_err    <= 1'b0;
    end else if (i_abort) begin
      // Abort leaves load_err and counters as they were for post-mortem.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_kernels <= i_num_kernels;
            r_word_cnt    <= '0;
            r_kernel_cnt  <= '0;
            r_load_err    <= 1'b0;
            r_state       <= S_ARM;
          end
        end
        S_ARM: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_final) begin
              if (!i_wht.wht_in_last) begin
                r_load_err <= 1'b1;
              end
              r_flush_cnt <= LP_FLUSH_LOAD;
              r_state     <= S_FLUSH;
            end else begin
              if (w_word_wrap) begin
                r_word_cnt   <= '0;
                r_kernel_cnt <= r_kernel_cnt + C_NUM_KERNELS_WIDTH'(1);
              end else begin
                r_word_cnt <= r_word_cnt + LP_WORD_W'(1);
              end
              if (i_wht.wht_in_last) begin
                r_load_err  <= 1'b1;
                r_flush_cnt <= LP_FLUSH_LOAD;
                r_state     <= S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt - LP_FLUSH_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered table write; a beat taken in the abort cycle is dropped so
  // no write lands after config_mode has fallen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wren <= 1'b0;
      r_data <= '0;
    end else begin
      r_wren <= w_accept && !i_abort;
      if (w_accept && !i_abort) begin
        r_data <= i_wht.wht_in_data;
      end
    end
  end

  assign i_wht.wht_in_ready = w_ready;
  assign o_config_mode      = (r_state == S_ARM) || (r_state == S_LOAD) || (r_state == S_FLUSH);
  assign o_job_accept       = (r_state == S_ARM);
  assign o_load_done        = (r_state == S_DONE);
  assign o_wht_config_wren  = r_wren;
  assign o_wht_config_data  = r_data;
  assign o_load_err         = r_load_err;
  assign o_kernel_cnt       = r_kernel_cnt;

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// Directed bench for the weight loader: each job's writes, pulses and error
// flag are logged by a monitor and compared against hand-computed values.
module tb_cnn_layer_accel_weight_loader;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        start       = 1'b0;
  logic        abort       = 1'b0;
  logic [5:0]  num_kernels = '0;
  logic        config_mode;
  logic        job_accept;
  logic        wren;
  logic [15:0] wdata;
  logic        load_done;
  logic        load_err;
  logic [5:0]  kernel_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] q_data[$];
  int          q_cyc[$];
  int          n_done   = 0;
  int          done_cyc = -1;
  int          n_ja     = 0;
  int          ja_cyc   = -1;
  int          n_viol   = 0;

  cnn_layer_accel_weight_loader_if #(.C_WEIGHT_WIDTH(16)) u_wht ();

  cnn_layer_accel_weight_loader #(
    .C_KERNEL_WORDS      (9),
    .C_NUM_KERNELS_WIDTH (6),
    .C_WEIGHT_WIDTH      (16),
    .C_FLUSH_CYCLES      (2)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (start),
    .i_abort           (abort),
    .i_num_kernels     (num_kernels),
    .i_wht             (u_wht),
    .o_config_mode     (config_mode),
    .o_job_accept      (job_accept),
    .o_wht_config_wren (wren),
    .o_wht_config_data (wdata),
    .o_load_done       (load_done),
    .o_load_err        (load_err),
    .o_kernel_cnt      (kernel_cnt)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: cycle index seen here equals the number of edges so far
  initial forever begin
    @(negedge clk);
    if (wren) begin
      q_data.push_back(wdata);
      q_cyc.push_back(cyc);
      if (!config_mode) n_viol++;
    end
    if (load_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (job_accept) begin
      n_ja++;
      ja_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_data.delete();
    q_cyc.delete();
    n_done   = 0;
    done_cyc = -1;
    n_ja     = 0;
    ja_cyc   = -1;
  endtask

  task automatic start_job(input logic [5:0] nk, output int t);
    num_kernels = nk;
    start       = 1'b1;
    t           = cyc;
    tick();
    start       = 1'b0;
  endtask

  // offers one beat; returns the cycle in which it was accepted
  task automatic send_beat(input logic [15:0] d, input logic l, output int t);
    bit got = 0;
    u_wht.wht_in_valid = 1'b1;
    u_wht.wht_in_data  = d;
    u_wht.wht_in_last  = l;
    t = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (u_wht.wht_in_ready) begin
        t   = cyc;
        got = 1;
      end
      tick();
    end
    if (!got) chk("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n0 = n_done;
    for (int k = 0; k < 40 && n_done == n0; k++) tick();
    chk(tag, n_done - n0, 1);
  endtask

  task automatic chk_writes(input string tag, input int n, input int base);
    int errs = 0;
    chk({tag, "_nwr"}, q_data.size(), n);
    for (int i = 0; i < q_data.size() && i < n; i++)
      if (q_data[i] !== 16'(base + i)) errs++;
    chk({tag, "_wdata"}, errs, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, u_wht.wht_in_ready, 0);
    chk({tag, "_cm"},    config_mode, 0);
    chk({tag, "_ja"},    job_accept, 0);
    chk({tag, "_wren"},  wren, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_done"},  load_done, 0);
    chk({tag, "_err"},   load_err, 0);
    chk({tag, "_kcnt"},  kernel_cnt, 0);
  endtask

  initial begin
    int t0;
    int tb;

    u_wht.wht_in_valid = 1'b0;
    u_wht.wht_in_data  = '0;
    u_wht.wht_in_last  = 1'b0;

    repeat (3) tick();
    chk_reset("rst_held");
    rst = 1'b0;
    tick();
    chk_reset("rst_idle");

    // basic: two kernels, continuous beats
    clear_log();
    start_job(6'd1, t0);
    chk("basic_ja_arm", job_accept, 1);
    chk("basic_cm_arm", config_mode, 1);
    chk("basic_rdy_arm", u_wht.wht_in_ready, 0);
    tick();
    chk("basic_rdy_load", u_wht.wht_in_ready, 1);
    for (int i = 1; i <= 18; i++) begin
      if (i == 9)  chk("basic_kcnt_k0", kernel_cnt, 0);
      if (i == 10) chk("basic_kcnt_k1", kernel_cnt, 1);
      send_beat(16'(i), i == 18, tb);
    end
    u_wht.wht_in_valid = 1'b0;
    u_wht.wht_in_last  = 1'b0;
    wait_done("basic_done");
    chk("basic_done_cyc", done_cyc, t0 + 22);
    chk("basic_ja_cyc", ja_cyc, t0 + 1);
    chk("basic_ja_cnt", n_ja, 1);
    chk_writes("basic", 18, 1);
    chk("basic_wr_first", (q_cyc.size() > 0) ? q_cyc[0] : -1, t0 + 3);
    chk("basic_wr_span", (q_cyc.size() > 0) ? q_cyc[q_cyc.size()-1] - q_cyc[0] : -1, 17);
    chk("basic_err", load_err, 0);
    chk("basic_kcnt_end", kernel_cnt, 1);

    // bubbles: valid every other cycle, one kernel
    clear_log();
    start_job(6'd0, t0);
    for (int i = 1; i <= 9; i++) begin
      send_beat(16'h0100 + 16'(i), i == 9, tb);
      u_wht.wht_in_valid = 1'b0;
      tick();
    end
    u_wht.wht_in_last = 1'b0;
    wait_done("bub_done");
    chk("bub_done_cyc", done_cyc, tb + 3);
    chk_writes("bub", 9, 16'h0101);
    chk("bub_err", load_err, 0);

    // early last on beat 5 of a three-kernel job
    clear_log();
    start_job(6'd2, t0);
    for (int i = 1; i <= 5; i++) send_beat(16'h0200 + 16'(i), i == 5, tb);
    u_wht.wht_in_valid = 1'b0;
    u_wht.wht_in_last  = 1'b0;
    chk("early_rdy_low", u_wht.wht_in_ready, 0);
    wait_done("early_done");
    chk("early_done_cyc", done_cyc, tb + 3);
    chk_writes("early", 5, 16'h0201);
    chk("early_err", load_err, 1);

    // missing last, then a clean job clears the error
    clear_log();
    start_job(6'd0, t0);
    for (int i = 1; i <= 9; i++) send_beat(16'h0300 + 16'(i), 1'b0, tb);
    u_wht.wht_in_valid = 1'b0;
    wait_done("miss_done");
    chk_writes("miss", 9, 16'h0301);
    chk("miss_err", load_err, 1);
    clear_log();
    start_job(6'd0, t0);
    chk("miss_err_clr", load_err, 0);
    for (int i = 1; i <= 9; i++) send_beat(16'h0310 + 16'(i), i == 9, tb);
    u_wht.wht_in_valid = 1'b0;
    u_wht.wht_in_last  = 1'b0;
    wait_done("clean_done");
    chk_writes("clean", 9, 16'h0311);
    chk("clean_err", load_err, 0);

    // abort after beat 4, then a full clean job
    clear_log();
    start_job(6'd1, t0);
    for (int i = 1; i <= 4; i++) send_beat(16'h0400 + 16'(i), 1'b0, tb);
    u_wht.wht_in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cm", config_mode, 0);
    chk("abort_rdy", u_wht.wht_in_ready, 0);
    chk("abort_wren", wren, 0);
    repeat (6) tick();
    chk("abort_no_done", n_done, 0);
    chk_writes("abort", 4, 16'h0401);
    clear_log();
    start_job(6'd1, t0);
    for (int i = 1; i <= 18; i++) send_beat(16'h0500 + 16'(i), i == 18, tb);
    u_wht.wht_in_valid = 1'b0;
    u_wht.wht_in_last  = 1'b0;
    wait_done("post_abort_done");
    chk("post_abort_done_cyc", done_cyc, t0 + 22);
    chk_writes("post_abort", 18, 16'h0501);
    chk("post_abort_err", load_err, 0);

    // start pulsed mid-load is ignored
    clear_log();
    start_job(6'd0, t0);
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) start = 1'b1;
      send_beat(16'h0600 + 16'(i), i == 9, tb);
      start = 1'b0;
    end
    u_wht.wht_in_valid = 1'b0;
    u_wht.wht_in_last  = 1'b0;
    wait_done("busy_done");
    repeat (3) tick();
    chk("busy_ja_cnt", n_ja, 1);
    chk("busy_done_cnt", n_done, 1);
    chk_writes("busy", 9, 16'h0601);

    // reset while in FLUSH after an early last in kernel 1
    clear_log();
    start_job(6'd1, t0);
    for (int i = 1; i <= 10; i++) send_beat(16'h0700 + 16'(i), i == 10, tb);
    u_wht.wht_in_valid = 1'b0;
    u_wht.wht_in_last  = 1'b0;
    chk("flush_err", load_err, 1);
    chk("flush_kcnt", kernel_cnt, 1);
    chk("flush_wren", wren, 1);
    chk("flush_cm", config_mode, 1);
    rst = 1'b1;
    tick();
    chk_reset("flush_rst");
    rst = 1'b0;
    repeat (5) tick();
    chk("flush_rst_no_done", n_done, 0);

    chk("cm_during_wren", n_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
